// File: rtl/mxv_pkg.sv
// Shared types and default sizes for the mXv result collector.
package mxv_pkg;

    localparam int ELEMENT_WIDTH = 32;
    localparam int NO_OF_UNITS   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } collector_state_t;

endpackage

// File: rtl/mxv_burst_fifo.sv
// Synchronous burst FIFO; a push into a full FIFO is accepted when a pop happens the same cycle.
module mxv_burst_fifo #(
    parameter int width = 256,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(depth));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && reset && !flush)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mxv_result_collector.sv
// Captures mXv result bursts and serializes them into a result memory, one element per cycle.
// Optional running checksum enabled by defining MXV_COLLECTOR_CHECKSUM_EN.
module mxv_result_collector
    import mxv_pkg::*;
#(
    parameter int element_width          = ELEMENT_WIDTH,
    parameter int no_of_units            = NO_OF_UNITS,
    parameter int memories_address_width = 32,
    parameter int buf_depth              = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [memories_address_width-1:0] base_address,
    input  logic [31:0]                       total_rows,
    input  logic [no_of_units*element_width-1:0] mXv1_result,
    input  logic                              outsider_read_now,
    input  logic                              mXv1_finish,
    output logic                              wr_en,
    output logic [memories_address_width-1:0] wr_address,
    output logic [element_width-1:0]          wr_data,
    output logic                              busy,
    output logic                              done,
    output logic                              overflow,
    output logic [element_width-1:0]          checksum
);
    localparam int BW = no_of_units * element_width;
    localparam int CW = $clog2(no_of_units);

    collector_state_t                  state;
    logic [memories_address_width-1:0] base_q;
    logic [31:0]                       rows_q;
    logic [31:0]                       row_cnt;
    logic [BW-1:0]                     ser_buf;
    logic [BW-1:0]                     src;
    logic [BW-1:0]                     fifo_dout;
    logic [CW-1:0]                     ser_left;
    logic fifo_full, fifo_empty;
    logic active, start_ok, room, strobe, need, pop, bypass, push, drop, emit, finish_now, flush;

    assign active   = (state == ST_RUN) || (state == ST_DRAIN);
    assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign room     = row_cnt < rows_q;
    assign strobe   = outsider_read_now && (state == ST_RUN);
    assign need     = active && room && (ser_left == '0);
    assign pop      = need && !fifo_empty;
    // An idle serializer takes a strobe directly so element 0 appears the next cycle.
    assign bypass   = need && fifo_empty && strobe;
    assign push     = strobe && !bypass;
    assign emit     = active && room && ((ser_left != '0) || pop || bypass);
    assign src      = (ser_left != '0) ? ser_buf : (pop ? fifo_dout : mXv1_result);
    assign finish_now = active && (!room || ((state == ST_DRAIN) && fifo_empty && (ser_left == '0)));
    assign drop     = push && fifo_full && !pop && !finish_now;
    assign flush    = start_ok || finish_now;

    mxv_burst_fifo #(.width(BW), .depth(buf_depth)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (mXv1_result),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            base_q     <= '0;
            rows_q     <= '0;
            row_cnt    <= '0;
            ser_buf    <= '0;
            ser_left   <= '0;
            wr_en      <= 1'b0;
            wr_address <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            wr_en <= emit;
            if (emit) begin
                wr_address <= base_q + memories_address_width'(row_cnt);
                wr_data    <= src[BW-1 -: element_width];
                ser_buf    <= src << element_width;
                row_cnt    <= row_cnt + 32'd1;
            end
            // Running out of rows also abandons any padding left in the serializer.
            ser_left <= emit ? ((ser_left != '0) ? ser_left - CW'(1) : CW'(no_of_units - 1)) : '0;
            if (drop)
                overflow <= 1'b1;

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        base_q   <= base_address;
                        rows_q   <= total_rows;
                        row_cnt  <= '0;
                        overflow <= 1'b0;
                        if (total_rows == '0) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    if (finish_now) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if ((state == ST_RUN) && mXv1_finish) begin
                        state <= ST_DRAIN;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MXV_COLLECTOR_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!reset || start_ok)
            checksum <= '0;
        else if (wr_en)
            checksum <= {checksum[element_width-2:0], checksum[element_width-1]} ^ wr_data;
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_mxv_result_collector.sv
// Directed, table-driven bench for mxv_result_collector (NI=8, 32-bit elements, buf_depth=4).
module tb_mxv_result_collector;
    localparam int EW = 32;
    localparam int NI = 8;
    localparam int AW = 32;
    localparam int BW = EW * NI;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_address = '0;
    logic [31:0]   total_rows = '0;
    logic [BW-1:0] mXv1_result = '0;
    logic          outsider_read_now = 1'b0;
    logic          mXv1_finish = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_address;
    logic [EW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [EW-1:0] checksum;

    mxv_result_collector #(
        .element_width(EW), .no_of_units(NI), .memories_address_width(AW), .buf_depth(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_address(base_address),
        .total_rows(total_rows), .mXv1_result(mXv1_result),
        .outsider_read_now(outsider_read_now), .mXv1_finish(mXv1_finish),
        .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data), .busy(busy),
        .done(done), .overflow(overflow), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] cap_addr[$];
    logic [31:0] cap_data[$];
    int          cap_cyc[$];
    int          done_cyc = -1;

    always @(negedge clk) begin
        if (wr_en) begin
            cap_addr.push_back(wr_address);
            cap_data.push_back(wr_data);
            cap_cyc.push_back(cyc);
        end
        if (done && done_cyc < 0)
            done_cyc = cyc;
    end

    int n_vec = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] mk_burst(input int b);
        logic [BW-1:0] r;
        r = '0;
        for (int k = 0; k < NI; k++)
            r[(NI-1-k)*EW +: EW] = 32'(b * NI + k + 1);
        return r;
    endfunction

    typedef struct {
        logic [31:0] base;
        logic [31:0] rows;
        int          nstb;
        int          gap;
        bit          fin_last;
        bit          extra;
        int          exp_wr;
        bit          exp_ovf;
    } vec_t;

    vec_t vt[7];

    task automatic run_vec(input vec_t v, input int idx);
        int s, stb0, k, n;
        logic [31:0] chk, ea;
        @(posedge clk); #1;
        base_address = v.base;
        total_rows   = v.rows;
        start        = 1'b1;
        s            = cyc;
        stb0         = -1;
        @(posedge clk); #1;
        start = 1'b0;
        cap_addr.delete();
        cap_data.delete();
        cap_cyc.delete();
        done_cyc = -1;
        for (int b = 0; b < v.nstb; b++) begin
            if (b == 0) stb0 = cyc;
            outsider_read_now = 1'b1;
            mXv1_result       = mk_burst(b);
            mXv1_finish       = v.fin_last && (b == v.nstb - 1);
            @(posedge clk); #1;
            outsider_read_now = 1'b0;
            mXv1_finish       = 1'b0;
            if (b < v.nstb - 1)
                repeat (v.gap - 1) begin @(posedge clk); #1; end
        end
        if (!v.fin_last) begin
            mXv1_finish = 1'b1;
            @(posedge clk); #1;
            mXv1_finish = 1'b0;
        end
        if (v.extra) begin
            repeat (2) begin @(posedge clk); #1; end
            outsider_read_now = 1'b1;
            mXv1_result       = {NI{32'hDEAD_BEEF}};
            @(posedge clk); #1;
            outsider_read_now = 1'b0;
        end
        k = 0;
        while (!done && k < 600) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check($sformatf("v%0d done", idx), 64'(done), 64'd1);
        check($sformatf("v%0d busy", idx), 64'(busy), 64'd0);
        check($sformatf("v%0d overflow", idx), 64'(overflow), 64'(v.exp_ovf));
        check($sformatf("v%0d write count", idx), 64'(cap_data.size()), 64'(v.exp_wr));
        n = (cap_data.size() < v.exp_wr) ? cap_data.size() : v.exp_wr;
        chk = '0;
        for (int i = 0; i < v.exp_wr; i++)
            chk = {chk[30:0], chk[31]} ^ 32'(i + 1);
        for (int i = 0; i < n; i++) begin
            ea = v.base + 32'(i);
            check($sformatf("v%0d addr[%0d]", idx, i), 64'(cap_addr[i]), 64'(ea));
            check($sformatf("v%0d data[%0d]", idx, i), 64'(cap_data[i]), 64'(i + 1));
            check($sformatf("v%0d cycle[%0d]", idx, i), 64'(cap_cyc[i]), 64'(stb0 + 1 + i));
        end
        if (n > 0)
            check($sformatf("v%0d done cycle", idx), 64'(done_cyc), 64'(cap_cyc[n-1] + 1));
        else
            check($sformatf("v%0d done cycle", idx), 64'(done_cyc), 64'(s + 1));
`ifdef MXV_COLLECTOR_CHECKSUM_EN
        check($sformatf("v%0d checksum", idx), 64'(checksum), 64'(chk));
`else
        check($sformatf("v%0d checksum", idx), 64'(checksum), 64'd0);
`endif
    endtask

    initial begin
        vec_t rv;
        int   k;
        //         base           rows nstb gap fin extra wr ovf
        vt[0] = '{32'h0000_0100, 16,  2,  8,  0,  0,  16, 0};
        vt[1] = '{32'h0000_0200, 20,  3,  8,  0,  0,  20, 0};
        vt[2] = '{32'h0000_0300, 48,  6,  1,  0,  0,  40, 1};
        vt[3] = '{32'h0000_0400, 64,  3,  1,  1,  1,  24, 0};
        vt[4] = '{32'hFFFF_FFFE, 4,   1,  8,  0,  0,  4,  0};
        vt[5] = '{32'h0000_0010, 0,   0,  8,  0,  0,  0,  0};
        vt[6] = '{32'h0000_0040, 2,   1,  8,  0,  0,  2,  0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset wr_en", 64'(wr_en), 64'd0);
        check("reset wr_address", 64'(wr_address), 64'd0);
        check("reset wr_data", 64'(wr_data), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset overflow", 64'(overflow), 64'd0);
        check("reset checksum", 64'(checksum), 64'd0);
        reset = 1'b1;

        for (int i = 0; i < 7; i++)
            run_vec(vt[i], i);

        // Reset in the middle of a burst, then re-arm at a new base.
        @(posedge clk); #1;
        base_address = 32'h500;
        total_rows   = 32'd16;
        start        = 1'b1;
        @(posedge clk); #1;
        start             = 1'b0;
        outsider_read_now = 1'b1;
        mXv1_result       = mk_burst(0);
        @(posedge clk); #1;
        outsider_read_now = 1'b0;
        k = 0;
        while (!(wr_en && wr_data == 32'd4) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("midreset reached element 3", 64'(wr_data), 64'd4);
        reset = 1'b0;
        @(posedge clk); #1;
        check("midreset wr_en", 64'(wr_en), 64'd0);
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset wr_address", 64'(wr_address), 64'd0);
        check("midreset overflow", 64'(overflow), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        rv = '{32'h0000_0600, 8, 1, 8, 0, 0, 8, 0};
        run_vec(rv, 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mxv_result_collector.md
# mxv_result_collector

Consumer end of the sparse matrix-by-vector result interface. It captures each wide result burst (`mXv1_result` qualified by `outsider_read_now`) from `matrix_by_vector_v3_with_control`, buffers it, and serializes it one element per cycle into a narrow result-vector memory at consecutive addresses. It counts written rows against the real row count, drops padding rows, and reports completion. It replaces the bench-side `$display` sink so results feed the next solver stage.

## Interface
- `element_width`, 32, bits per element
- `no_of_units`, 8, elements per burst (NI)
- `memories_address_width`, 32, result memory address width
- `buf_depth`, 4, burst FIFO depth in bursts (power of two, ≥2)
- `clk` in 1: single clock, all logic on posedge
- `reset` in 1: reset is synchronous and active-low (`reset==0` at a posedge resets)
- `start` in 1: arm pulse; latches `base_address` and `total_rows`
- `base_address` in `memories_address_width`: first write address
- `total_rows` in 32: real rows to store (excludes padding)
- `mXv1_result` in `no_of_units*element_width`: burst data, element 0 in the MS slice
- `outsider_read_now` in 1: burst valid strobe, one cycle per burst
- `mXv1_finish` in 1: producer finished, no further bursts
- `wr_en` out 1: result memory write strobe
- `wr_address` out `memories_address_width`: write address
- `wr_data` out `element_width`: write data
- `busy` out 1: armed and not done
- `done` out 1: level, all rows written
- `overflow` out 1: sticky, a burst was dropped
- `checksum` out `element_width`: see Configuration

## Operation
- States: IDLE, RUN, DRAIN, DONE (encoding in package).
- IDLE: strobes ignored. `start` -> RUN; latch base, `total_rows`; clear row count, FIFO, `overflow`, checksum.
- RUN: strobe pushes burst. `mXv1_finish` -> DRAIN (a strobe in the same cycle is still pushed).
- DRAIN: strobes ignored; FIFO empty and serializer idle -> DONE.
- Any state: row count reaching `total_rows` -> DONE; remaining FIFO contents discarded.
- DONE: holds; `start` -> RUN (re-arm).
- `start` while RUN/DRAIN: ignored.
- Serializer pops head burst, emits elements 0..NI-1, one per cycle. `wr_address` = base + row count. Row count +1 per write, 32-bit, no wrap needed.
- Elements at row index ≥ `total_rows`: not written; serializer stops.
- `total_rows==0`: `start` -> DONE the next cycle; no writes.
- FIFO full + strobe: burst dropped, `overflow` set, unless a pop occurs the same cycle (then push accepted).
- Address arithmetic is modulo 2^`memories_address_width`.

## Timing
- Reset values: `wr_en`=0, `wr_address`=0, `wr_data`=0, `busy`=0, `done`=0, `overflow`=0, `checksum`=0, state IDLE, FIFO empty.
- Strobe at cycle t (FIFO empty, serializer idle): element 0 registered on `wr_en` at t+1; element k at t+1+k.
- Back-to-back bursts: continuous `wr_en`, no bubble between bursts.
- Sustained rate: one burst per NI cycles; a faster average rate is absorbed only up to `buf_depth`.
- `done` rises the cycle after the last write is presented; `busy` falls the same cycle.
- Reset mid-operation: all outputs return to reset values at that edge; in-flight data lost.

## Configuration
- `MXV_COLLECTOR_CHECKSUM_EN` defined: `checksum` = running value, each write `checksum <= {checksum[element_width-2:0], checksum[element_width-1]} ^ wr_data`, cleared on `start`.
- Undefined: `checksum` tied to 0, no accumulator logic.

## Structure
- Package `mxv_pkg`: collector state typedef, default `element_width`/`no_of_units` constants.
- Sub-module `mxv_burst_fifo`: synchronous FIFO of `no_of_units*element_width` words, push/pop/full/empty, simultaneous push+pop when full allowed.

## Test plan
- NI=8, base=0x100, total_rows=16, two strobes 8 cycles apart, elements 0x1..0x10 -> 16 writes 0x100..0x10F, data 0x1..0x10, `done` 1 cycle after last.
- total_rows=20, three bursts (24 elements incl. padding) -> exactly 20 writes, last to base+19, padding never written.
- buf_depth=4, six strobes on consecutive cycles -> five bursts stored (one pop frees a slot), one dropped, `overflow`=1, 40 writes.
- `mXv1_finish` with strobe same cycle, two bursts queued -> all queued bursts written, later strobes ignored, DONE after drain.
- `reset`=0 during burst element 3 -> `wr_en`=0, `busy`=0 next cycle; after `start`, row count restarts at base.
- With `MXV_COLLECTOR_CHECKSUM_EN`, data 0x1,0x2 -> checksum 0x1 then 0x0; without macro -> checksum 0 always.
